pc_update: RTL

PC_UPDATE -- requirements
Module: pc_update

---
 rtl/pc_update.sv | 126 ++++++++++++
 1 files changed

// File: rtl/pc_update.sv
// pc_update: single-issue fetch/issue/resolve PC sequencer.
// Ports: clk, rst_n (sync, active-low), imem_* fetch port,
//   instr_* decode handshake, resolve_valid/branch_* from execute,
//   pc, trap, retire_cnt status. Optional macro PC_UPDATE_TRAP_EN.
module pc_update #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        resolve_valid,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] pc,
  output logic        trap,
  output logic [31:0] retire_cnt
);

  localparam logic [1:0] FETCH   = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] RESOLVE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        trap_q, trap_d;
  logic [31:0] tgt_addr;

  // Sign-magnitude target folded to a positive, word-aligned
  // address; negative zero lands on 0.
  assign tgt_addr = {1'b0, branch_target[30:2], 2'b00};

`ifdef PC_UPDATE_TRAP_EN
  logic tgt_bad;
  assign tgt_bad = (branch_target[31] && (|branch_target[30:0]))
                 || (|branch_target[1:0]);
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    cnt_d   = cnt_q;
    trap_d  = 1'b0;
    case (state_q)
      FETCH: begin
        // req_q gates the ack so the dead cycle after reset
        // cannot accept a stray acknowledge.
        if (req_q && imem_ack) begin
          instr_d = imem_rdata;
          ipc_d   = pc_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (instr_ready) state_d = RESOLVE;
      end
      RESOLVE: begin
        if (resolve_valid) begin
          cnt_d   = cnt_q + 32'd1;
          state_d = FETCH;
          if (!branch_taken) begin
            pc_d = pc_q + 32'd4;
          end else begin
`ifdef PC_UPDATE_TRAP_EN
            if (tgt_bad) begin
              pc_d   = TRAP_PC;
              trap_d = 1'b1;
            end else begin
              pc_d = tgt_addr;
            end
`else
            pc_d = tgt_addr;
`endif
          end
        end
      end
      default: state_d = FETCH;
    endcase
    // Registered request: low the cycle after reset or ack,
    // high the cycle after resolve.
    req_d = (state_d == FETCH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'd0;
      ipc_q   <= 32'd0;
      cnt_q   <= 32'd0;
      req_q   <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      trap_q  <= trap_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == ISSUE);
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign pc          = pc_q;
  assign trap        = trap_q;
  assign retire_cnt  = cnt_q;

endmodule
